// File: rtl/pb_uart_rx_monitor_pkg.sv
// Shared types and constants for the UART receive monitor.
package pb_uart_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam logic [7:0] AsciiLf = 8'h0A;

endpackage

// File: rtl/pb_uart_rx_monitor_fifo.sv
// Small synchronous FIFO; the head entry is visible on data_o whenever not empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module pb_uart_rx_monitor_fifo #(
  parameter int unsigned Depth     = 16,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 empty_o,
  output logic                 full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q;
  logic                 push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only observable once written, and
  // the consumer-facing byte is masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pb_uart_rx_monitor.sv
// 8N1 UART receive monitor: synchronises the line, deserialises frames and
// buffers received bytes for a console consumer.
module pb_uart_rx_monitor
  import pb_uart_mon_pkg::*;
#(
  parameter int unsigned BaudDiv   = 868,
  parameter int unsigned FifoDepth = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       rx_i,
  output logic       reading_byte_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       line_done_o,
  output logic       frame_err_o,
  output logic       overflow_o
);

  localparam int unsigned     CntW       = $clog2(BaudDiv);
  localparam logic [CntW-1:0] FullReload = CntW'(BaudDiv - 1);
  localparam logic [CntW-1:0] HalfReload = CntW'(BaudDiv / 2 - 1);

  rx_state_e       state_q;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            line_done_q, frame_err_q, overflow_q;

  logic       stop_sample, push, pop, fifo_empty, fifo_full;
  logic [7:0] fifo_head;

  assign stop_sample = en_i && (state_q == STOP) && (cnt_q == '0);
  assign push        = stop_sample && rx_s_q;
  assign pop         = byte_valid_o && byte_ready_i;

  pb_uart_rx_monitor_fifo #(
    .Depth    (FifoDepth),
    .DataWidth(8)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (shift_q),
    .pop_i  (pop),
    .data_o (fifo_head),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  // Synchroniser idles high so reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the values from before this clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      line_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      line_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;

      if (!en_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            // Needs a high rx_s first, so a low line after a bad stop bit waits.
            if (rx_prev_q && !rx_s_q) begin
              state_q <= START;
              cnt_q   <= HalfReload;
            end
          end
          START: begin
            if (cnt_q == '0) begin
              if (!rx_s_q) begin
                state_q <= DATA;
                cnt_q   <= FullReload;
                bit_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          DATA: begin
            if (cnt_q == '0) begin
              shift_q <= {rx_s_q, shift_q[7:1]};
              cnt_q   <= FullReload;
              if (bit_q == 3'd7) state_q <= STOP;
              else               bit_q   <= bit_q + 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          STOP: begin
            if (cnt_q == '0) begin
              state_q <= IDLE;
              if (rx_s_q) line_done_q <= (shift_q == AsciiLf);
              else        frame_err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign reading_byte_o = (state_q != IDLE);
  assign byte_valid_o   = ~fifo_empty;
  assign byte_o         = byte_valid_o ? fifo_head : 8'h00;
  assign line_done_o    = line_done_q;
  assign frame_err_o    = frame_err_q;
  assign overflow_o     = overflow_q;

endmodule
